// File: rtl/morse_pkg.sv
// Shared definitions for the Morse transmit scheduler.
//   state_t  : scheduler FSM state. The encoding is also shown on the debug LEDs.
//   letter_t : 3-bit letter codes A..H understood by the single-LED encoder.
//   umax     : elaboration-time helper used to size counters.
package morse_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    GAP   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    L_A = 3'd0,
    L_B = 3'd1,
    L_C = 3'd2,
    L_D = 3'd3,
    L_E = 3'd4,
    L_F = 3'd5,
    L_G = 3'd6,
    L_H = 3'd7
  } letter_t;

  function automatic int umax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/morse_tx_scheduler_tick_prescaler.sv
// Free-running time-unit prescaler.
//   CLOCK_50 : system clock, rising edge
//   ResetN   : asynchronous active-low reset; the counter restarts at 0
//   tick     : high for exactly one cycle every TICK_DIV cycles, while cnt == TICK_DIV-1
module tick_prescaler #(
  parameter int TICK_DIV = 25000000
) (
  input  logic CLOCK_50,
  input  logic ResetN,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // NOTE: clocked state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of process order.
  always_ff @(posedge CLOCK_50 or negedge ResetN) begin
    if (!ResetN) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/morse_tx_scheduler.sv
// Round-robin scheduler that shares one Morse letter encoder among NREQ requesters.
// It grants one requester, starts the encoder on that requester's letter and waits
// for done or a timeout. It then holds an inter-letter gap, acks the owner and
// arbitrates again.
//   CLOCK_50, ResetN : clock and asynchronous active-low reset
//   req [NREQ]       : level requests, held until ack
//   letter_in [3*NREQ]: letter code per requester, slice i = [3i+2:3i]
//   grant [NREQ]     : one-hot current owner, zero when none
//   ack [NREQ]       : one-cycle pulse to the owner at the end of its gap
//   err              : one-cycle pulse with ack when that letter timed out
//   enc_start        : one-cycle start pulse to the encoder
//   enc_letter [3]   : latched letter, stable while grant != 0
//   enc_abort        : one-cycle abort pulse to the encoder on timeout
//   enc_done         : one-cycle pulse from the encoder, honoured only in WAIT
//   busy             : state != IDLE
//   LEDG [3]         : current state encoding for board debug
module morse_tx_scheduler
  import morse_pkg::*;
#(
  parameter int NREQ          = 4,
  parameter int TICK_DIV      = 25000000,
  parameter int GAP_UNITS     = 3,
  parameter int TIMEOUT_UNITS = 16
) (
  input  logic              CLOCK_50,
  input  logic              ResetN,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] letter_in,
  output logic [NREQ-1:0]   grant,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic              enc_start,
  output logic [2:0]        enc_letter,
  output logic              enc_abort,
  input  logic              enc_done,
  output logic              busy,
  output logic [2:0]        LEDG
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  // The unit counter counts both the gap and the timeout, so it is sized for the larger.
  localparam int UW = $clog2(umax(GAP_UNITS, TIMEOUT_UNITS) + 1);
  localparam logic [UW-1:0] GAP_U     = UW'(GAP_UNITS);
  localparam logic [UW-1:0] TIMEOUT_U = UW'(TIMEOUT_UNITS);

  logic tick;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .CLOCK_50(CLOCK_50),
    .ResetN  (ResetN),
    .tick    (tick)
  );

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [2:0]      letter_q, letter_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [UW-1:0]   unit_q, unit_d, unit_inc;
  logic            err_flag_q, err_flag_d;

  // Arbiter: rotate req so that bit 0 is requester rr_ptr+1, take the lowest
  // set bit, then map that offset back to a requester index mod NREQ.
  logic [NREQ-1:0] rot;
  logic            win_found;
  logic [PW:0]     win_off, win_sum;
  logic [PW-1:0]   win_idx;
  logic [2:0]      letter_sel;

  // NOTE: every signal driven from always_comb gets a default at the top of the
  // block. No path can then leave it unassigned, so no latch is inferred.
  always_comb begin
    rot       = NREQ'({req, req} >> ({1'b0, rr_ptr_q} + 1'b1));
    win_found = 1'b0;
    win_off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        win_found = 1'b1;
        win_off   = (PW+1)'(i);
      end
    end
    win_sum = {1'b0, rr_ptr_q} + win_off + 1'b1;
    if (win_sum >= (PW+1)'(NREQ)) begin
      win_sum = win_sum - (PW+1)'(NREQ);
    end
    win_idx = win_sum[PW-1:0];
  end

  always_comb begin
    letter_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == PW'(i)) begin
        letter_sel = letter_in[3*i +: 3];
      end
    end
  end

  // The counter saturates instead of wrapping. A stray extra tick can then never
  // bring it back below a threshold.
  assign unit_inc = (unit_q == '1) ? unit_q : unit_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    letter_d   = letter_q;
    rr_ptr_d   = rr_ptr_q;
    unit_d     = unit_q;
    err_flag_d = err_flag_q;
    enc_start  = 1'b0;
    enc_abort  = 1'b0;
    ack        = '0;
    err        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req) state_d = ARB;
      end

      ARB: begin
        // The request may have been withdrawn since IDLE saw it. In that case drop back quietly.
        if (win_found) begin
          grant_d  = NREQ'(1'b1) << win_idx;
          letter_d = letter_sel;
          rr_ptr_d = win_idx;
          state_d  = START;
        end else begin
          state_d = IDLE;
        end
      end

      START: begin
        enc_start = 1'b1;
        unit_d    = '0;
        state_d   = WAIT;
      end

      WAIT: begin
        // done is tested first, so a done that arrives on the timeout tick counts as success.
        if (enc_done) begin
          unit_d  = '0;
          state_d = GAP;
        end else if (tick) begin
          unit_d = unit_inc;
          if (unit_inc == TIMEOUT_U) begin
            enc_abort  = 1'b1;
            err_flag_d = 1'b1;
            unit_d     = '0;
            state_d    = GAP;
          end
        end
      end

      GAP: begin
        if (tick) begin
          unit_d = unit_inc;
          if (unit_inc == GAP_U) begin
            ack        = grant_q;
            err        = err_flag_q;
            grant_d    = '0;
            err_flag_d = 1'b0;
            unit_d     = '0;
            state_d    = (|req) ? ARB : IDLE;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      letter_q   <= '0;
      rr_ptr_q   <= PW'(NREQ - 1);
      unit_q     <= '0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      letter_q   <= letter_d;
      rr_ptr_q   <= rr_ptr_d;
      unit_q     <= unit_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign grant      = grant_q;
  assign enc_letter = letter_q;
  assign busy       = (state_q != IDLE);
  assign LEDG       = state_q;

endmodule

// File: tb/tb_morse_tx_scheduler.sv
// Scoreboard bench for morse_tx_scheduler (NREQ=4, TICK_DIV=4, GAP_UNITS=3, TIMEOUT_UNITS=16).
// Stimulus queues the expected START/ABORT/ACK events, each with the cycle it must
// occur in. The monitor pops and compares whenever the DUT shows one.
module tb_morse_tx_scheduler;
  import morse_pkg::*;

  localparam int NREQ          = 4;
  localparam int TICK_DIV      = 4;
  localparam int GAP_UNITS     = 3;
  localparam int TIMEOUT_UNITS = 16;

  logic              CLOCK_50 = 1'b0;
  logic              ResetN   = 1'b1;
  logic [NREQ-1:0]   req      = '0;
  logic [3*NREQ-1:0] letter_in = '0;
  logic              enc_done = 1'b0;
  logic [NREQ-1:0]   grant, ack;
  logic              err, enc_start, enc_abort, busy;
  logic [2:0]        enc_letter, LEDG;

  morse_tx_scheduler #(
    .NREQ(NREQ), .TICK_DIV(TICK_DIV), .GAP_UNITS(GAP_UNITS), .TIMEOUT_UNITS(TIMEOUT_UNITS)
  ) dut (
    .CLOCK_50(CLOCK_50), .ResetN(ResetN), .req(req), .letter_in(letter_in),
    .grant(grant), .ack(ack), .err(err), .enc_start(enc_start), .enc_letter(enc_letter),
    .enc_abort(enc_abort), .enc_done(enc_done), .busy(busy), .LEDG(LEDG)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks   = 0;
  int failures = 0;

  // Reference timebase. Cycle n is the interval after the n-th rising edge since
  // reset release. A time unit ends in every cycle with n % TICK_DIV == TICK_DIV-1.
  int cyc;
  always @(posedge CLOCK_50 or negedge ResetN) begin
    if (!ResetN) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  typedef enum int {EV_START, EV_ABORT, EV_ACK} ev_kind_t;
  typedef struct {
    ev_kind_t        kind;
    logic [NREQ-1:0] who;
    logic [2:0]      letter;
    logic            err;
    int              at;
  } ev_t;

  ev_t sb[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d, t=%0t)", name, actual, expected, cyc, $time);
    end
  endtask

  function automatic void expect_ev(input ev_kind_t k, input logic [NREQ-1:0] who,
                                    input logic [2:0] l, input logic e, input int at);
    ev_t x;
    x.kind = k; x.who = who; x.letter = l; x.err = e; x.at = at;
    sb.push_back(x);
  endfunction

  // Cycle of the n-th time-unit tick strictly after cycle c.
  function automatic int nth_tick_after(input int c, input int n);
    int k = c;
    int got = 0;
    while (got < n) begin
      k++;
      if (k % TICK_DIV == TICK_DIV - 1) got++;
    end
    return k;
  endfunction

  task automatic take(input ev_kind_t kind);
    ev_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got %s at cyc %0d, expected no event", kind.name(), cyc);
      return;
    end
    e = sb.pop_front();
    check("event_kind", int'(kind), int'(e.kind));
    check("event_cycle", cyc, e.at);
    case (kind)
      EV_START: begin
        check("start_grant", {28'd0, grant}, {28'd0, e.who});
        check("start_letter", {29'd0, enc_letter}, {29'd0, e.letter});
      end
      EV_ACK: begin
        check("ack_value", {28'd0, ack}, {28'd0, e.who});
        check("ack_err", {31'd0, err}, {31'd0, e.err});
      end
      default: ;
    endcase
  endtask

  // Monitor: sample on the falling edge, half a cycle away from the active edge.
  always @(negedge CLOCK_50) begin
    if (ResetN === 1'b1) begin
      if (enc_start === 1'b1) take(EV_START);
      if (enc_abort === 1'b1) take(EV_ABORT);
      if (|ack) take(EV_ACK);
      if (err === 1'b1 && !(|ack)) check("err_without_ack", {31'd0, err}, 32'd0);
    end
  end

  // Advance to just after the rising edge that begins cycle c.
  task automatic to_cyc(input int c);
    int guard = 0;
    while (cyc != c) begin
      @(posedge CLOCK_50);
      #1;
      guard++;
      if (guard > 2000) begin
        failures++;
        $display("FAIL to_cyc: got cyc %0d expected to reach %0d", cyc, c);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1);
      end
    end
  endtask

  task automatic do_reset();
    ResetN   = 1'b0;
    req      = '0;
    enc_done = 1'b0;
    #1;
    check("reset_outputs",
          {14'd0, grant, ack, err, enc_start, enc_letter, enc_abort, busy, LEDG}, 32'd0);
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #1;
    ResetN = 1'b1;
  endtask

  // Issue one letter. The START event must appear in cycle s, done is pulsed dly
  // cycles later, and the ACK is expected on the GAP_UNITS-th tick after done.
  task automatic serve(input logic [NREQ-1:0] who, input logic [2:0] l,
                       input int s, input int dly, output int k);
    expect_ev(EV_START, who, l, 1'b0, s);
    to_cyc(s + dly);
    enc_done = 1'b1;
    k = nth_tick_after(s + dly, GAP_UNITS);
    expect_ev(EV_ACK, who, 3'd0, 1'b0, k);
    @(posedge CLOCK_50);
    #1;
    enc_done = 1'b0;
  endtask

  task automatic check_idle(input string name);
    check(name, {27'd0, grant, busy}, 32'd0);
    check({name, "_ledg"}, {29'd0, LEDG}, {29'd0, IDLE});
  endtask

  logic [2:0] fair_l [4];

  initial begin
    int r, s, k, k2, a;
    fair_l = '{L_B, L_D, L_G, L_H};

    #2;
    do_reset();

    // 1: single request, letter C. Done falls on a tick, so the ack comes 12 cycles later.
    letter_in = {L_A, L_A, L_A, L_C};
    to_cyc(3);
    r = cyc;
    req = 4'b0001;
    serve(4'b0001, L_C, r + 2, 10, k);
    to_cyc(k);
    req = '0;
    to_cyc(k + 1);
    check_idle("t1_idle");

    // 2: fairness with all four requests held. Grant order 0,1,2,3,0.
    do_reset();
    letter_in = {L_H, L_G, L_D, L_B};
    to_cyc(1);
    req = 4'b1111;
    s = cyc + 2;
    for (int i = 0; i < 5; i++) begin
      serve(4'b0001 << (i % 4), fair_l[i % 4], s, 4 + i, k);
      s = k + 2;
    end
    req = '0;
    to_cyc(k + 1);
    check_idle("t2_idle");

    // 3: timeout. Abort on the 16th tick after start, then ack with err 3 ticks later.
    to_cyc(cyc + 1);
    r = cyc;
    req = 4'b0100;
    s = r + 2;
    a = nth_tick_after(s, TIMEOUT_UNITS);
    k = nth_tick_after(a, GAP_UNITS);
    expect_ev(EV_START, 4'b0100, L_G, 1'b0, s);
    expect_ev(EV_ABORT, 4'b0000, 3'd0, 1'b0, a);
    expect_ev(EV_ACK, 4'b0100, 3'd0, 1'b1, k);
    to_cyc(k);
    req = '0;
    to_cyc(k + 1);
    check_idle("t3_idle");

    // 6: done coincident with the 16th tick. Done wins: no abort and no err.
    to_cyc(cyc + 1);
    r = cyc;
    req = 4'b1000;
    s = r + 2;
    a = nth_tick_after(s, TIMEOUT_UNITS);
    serve(4'b1000, L_H, s, a - s, k);
    to_cyc(k);
    req = '0;
    to_cyc(k + 1);
    check_idle("t6_idle");

    // 4: req dropped and letter changed mid-WAIT, done pulsed in GAP and IDLE.
    to_cyc(cyc + 1);
    r = cyc;
    req = 4'b0010;
    s = r + 2;
    expect_ev(EV_START, 4'b0010, L_D, 1'b0, s);
    to_cyc(s + 3);
    req = '0;
    letter_in = {L_A, L_A, L_F, L_A};
    to_cyc(s + 4);
    check("t4_letter_frozen", {29'd0, enc_letter}, {29'd0, L_D});
    check("t4_grant_frozen", {28'd0, grant}, 32'h2);
    to_cyc(s + 6);
    enc_done = 1'b1;
    k = nth_tick_after(s + 6, GAP_UNITS);
    expect_ev(EV_ACK, 4'b0010, 3'd0, 1'b0, k);
    to_cyc(s + 7);
    enc_done = 1'b0;
    to_cyc(s + 8);
    enc_done = 1'b1;
    to_cyc(s + 9);
    enc_done = 1'b0;
    to_cyc(k + 2);
    enc_done = 1'b1;
    to_cyc(k + 3);
    enc_done = 1'b0;
    check_idle("t4_idle");

    // ARB with the request already withdrawn: back to IDLE with no grant.
    to_cyc(cyc + 1);
    r = cyc;
    req = 4'b0001;
    to_cyc(r + 1);
    req = '0;
    check("arb_ledg", {29'd0, LEDG}, {29'd0, ARB});
    to_cyc(r + 2);
    check_idle("arb_drop_idle");

    // 5: reset mid-WAIT on requester 0 (rr_ptr = 0). Afterwards requester 0 must win again.
    letter_in = {L_A, L_A, L_F, L_E};
    to_cyc(cyc + 1);
    r = cyc;
    req = 4'b0001;
    s = r + 2;
    expect_ev(EV_START, 4'b0001, L_E, 1'b0, s);
    to_cyc(s + 3);
    ResetN = 1'b0;
    req = '0;
    #1;
    check("t5_async_clear", {19'd0, grant, busy, LEDG, ack, enc_abort}, 32'd0);
    @(posedge CLOCK_50);
    #1;
    ResetN = 1'b1;
    to_cyc(2);
    r = cyc;
    req = 4'b0011;
    serve(4'b0001, L_E, r + 2, 5, k);
    to_cyc(k);
    req = 4'b0010;
    serve(4'b0010, L_F, k + 2, 5, k2);
    to_cyc(k2);
    req = '0;
    to_cyc(k2 + 1);
    check_idle("t5_idle");

    to_cyc(cyc + 20);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: got no completion by t=%0t expected bench to finish", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
